// File: rtl/rns_pkg.sv
// Shared RNS helpers: operand/residue widths per modulus and thermometer-code conversions.
// Every channel uses these helpers, so their argument and return widths cover the largest legal modulus (64).
package rns_pkg;

  localparam int MAX_MOD   = 64;
  localparam int MAX_TC_W  = MAX_MOD - 1;
  localparam int MAX_BIN_W = $clog2(MAX_MOD);

  typedef logic [MAX_TC_W-1:0]  tc_t;
  typedef logic [MAX_BIN_W-1:0] bin_t;

  function automatic int tc_width(input int mod);
    return mod - 1;
  endfunction

  function automatic int bin_width(input int mod);
    return $clog2(mod);
  endfunction

  // A legal code is a run of ones starting at bit 0, so adding one clears every set bit.
  function automatic logic tc_is_legal(input tc_t tc);
    return (tc & (tc + tc_t'(1))) == '0;
  endfunction

  function automatic bin_t tc_to_bin(input tc_t tc);
    bin_t n;
    n = '0;
    for (int i = 0; i < MAX_TC_W; i++) n += bin_t'(tc[i]);
    return tc_is_legal(tc) ? n : '0;
  endfunction

  function automatic tc_t bin_to_tc(input bin_t bin);
    return tc_t'((64'(1) << bin) - 64'(1));
  endfunction

endpackage

// File: rtl/tc_mod_accumulator_if.sv
// Operand and result streams of one RNS accumulator channel.
// The master modport drives operands; the slave modport is the accumulator side.
interface tc_mod_accumulator_if #(parameter int MOD = 11);
  import rns_pkg::*;

  localparam int TC_W  = tc_width(MOD);
  localparam int BIN_W = bin_width(MOD);

  logic             in_valid;
  logic             in_ready;
  logic [TC_W-1:0]  in_tc;
  logic             in_clear;
  logic             out_valid;
  logic             out_ready;
  logic [BIN_W-1:0] out_bin;
  logic [TC_W-1:0]  out_tc;
  logic             out_err;

  modport master (
    output in_valid, in_tc, in_clear, out_ready,
    input  in_ready, out_valid, out_bin, out_tc, out_err
  );

  modport slave (
    input  in_valid, in_tc, in_clear, out_ready,
    output in_ready, out_valid, out_bin, out_tc, out_err
  );

endinterface

// File: rtl/tc_mod_decode.sv
// Combinational thermometer-to-binary decoder with a legality flag.
// Illegal codes decode to zero.
module tc_mod_decode
  import rns_pkg::*;
#(
  parameter int MOD = 11
) (
  input  logic [tc_width(MOD)-1:0]  tc,
  output logic [bin_width(MOD)-1:0] bin,
  output logic                      legal
);

  localparam int BIN_W = bin_width(MOD);

  assign bin   = BIN_W'(tc_to_bin(tc_t'(tc)));
  assign legal = tc_is_legal(tc_t'(tc));

endmodule

// File: rtl/tc_mod_accumulator.sv
// Two-stage modulo-MOD accumulator: S1 decodes a TC operand, S2 adds it to the residue and re-encodes it.
// Defining TC_MOD_ACC_ERR_CHECK_EN builds the illegal-operand flag; otherwise out_err is tied to 0.
module tc_mod_accumulator
  import rns_pkg::*;
#(
  parameter int MOD = 11
) (
  input logic                 clk,
  input logic                 rst,
  tc_mod_accumulator_if.slave bus
);

  localparam int TC_W  = tc_width(MOD);
  localparam int BIN_W = bin_width(MOD);
  localparam logic [BIN_W:0] MOD_W = (BIN_W + 1)'(MOD);

  logic [BIN_W-1:0] dec_bin;
  logic             dec_legal;

  logic             s1_valid;
  logic             s1_clr;
  logic [BIN_W-1:0] s1_val;
  logic [BIN_W-1:0] acc;
  logic             out_valid_q;
  logic [TC_W-1:0]  out_tc_q;

  logic             accept;
  logic             advance;
  logic [BIN_W:0]   sum;
  logic [BIN_W-1:0] acc_next;

  tc_mod_decode #(.MOD(MOD)) u_decode (
    .tc    (bus.in_tc),
    .bin   (dec_bin),
    .legal (dec_legal)
  );

  assign advance = s1_valid && (!out_valid_q || bus.out_ready);
  // NOTE: in_ready is gated by rst combinationally so nothing is accepted on a reset edge.
  assign bus.in_ready = !rst && (!s1_valid || advance);
  assign accept       = bus.in_valid && bus.in_ready;

  // NOTE: every always_comb output gets its value on every path, so no latch is inferred.
  always_comb begin
    sum      = (s1_clr ? '0 : {1'b0, acc}) + {1'b0, s1_val};
    acc_next = (sum >= MOD_W) ? BIN_W'(sum - MOD_W) : BIN_W'(sum);
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_clr      <= 1'b0;
      s1_val      <= '0;
      acc         <= '0;
      out_valid_q <= 1'b0;
      out_tc_q    <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_val   <= dec_bin;
        s1_clr   <= bus.in_clear;
      end else if (advance) begin
        s1_valid <= 1'b0;
      end

      if (advance) begin
        acc         <= acc_next;
        out_tc_q    <= TC_W'(bin_to_tc(bin_t'(acc_next)));
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // The running residue is also the held result, so out_bin needs no separate register.
  assign bus.out_valid = out_valid_q;
  assign bus.out_bin   = acc;
  assign bus.out_tc    = out_tc_q;

`ifdef TC_MOD_ACC_ERR_CHECK_EN
  logic s1_err;
  logic out_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_err    <= 1'b0;
      out_err_q <= 1'b0;
    end else begin
      if (accept)  s1_err    <= !dec_legal;
      if (advance) out_err_q <= s1_err;
    end
  end

  assign bus.out_err = out_err_q;
`else
  logic legal_unused;
  assign legal_unused = dec_legal;
  assign bus.out_err  = 1'b0;
`endif

endmodule

// File: tb/tb_tc_mod_accumulator.sv
// Self-checking bench for tc_mod_accumulator: directed steps with random streams, scored by a residue model.
// The expected out_err follows TC_MOD_ACC_ERR_CHECK_EN.
module tb_tc_mod_accumulator;

  localparam int MOD  = 11;
  localparam int TW   = MOD - 1;
  localparam int MOD5 = 5;

`ifdef TC_MOD_ACC_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    int bin;
    bit err;
    int step;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tc_mod_accumulator_if #(.MOD(MOD))  bus ();
  tc_mod_accumulator_if #(.MOD(MOD5)) b5 ();

  tc_mod_accumulator #(.MOD(MOD))  dut  (.clk(clk), .rst(rst), .bus(bus.slave));
  tc_mod_accumulator #(.MOD(MOD5)) dut5 (.clk(clk), .rst(rst), .bus(b5.slave));

  int          total = 0;
  int          bad = 0;
  int          step_no = 0;
  int          model_acc = 0;
  bit          lat_chk = 1'b0;
  bit          in_fire = 1'b0;
  int          last_bin = -1;
  logic [TW-1:0] last_tc;
  logic        last_err;
  exp_t        exp_q[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Value of a TC operand: k for the code with ones in bits 0..k-1, 0 for anything else.
  function automatic int tc_value(input logic [TW-1:0] tc, output bit illegal);
    logic [TW:0] code;
    illegal = 1'b1;
    for (int k = 0; k <= TW; k++) begin
      code = '0;
      for (int i = 0; i < k; i++) code[i] = 1'b1;
      if ({1'b0, tc} == code) begin
        illegal = 1'b0;
        return k;
      end
    end
    return 0;
  endfunction

  function automatic logic [TW-1:0] tc_of(input int v);
    logic [TW-1:0] r;
    r = '0;
    for (int i = 0; i < v; i++) r[i] = 1'b1;
    return r;
  endfunction

  // Sample mid-cycle: anything valid&&ready now transfers on the coming rising edge.
  task automatic observe();
    int  v;
    bit  ill;
    in_fire = 1'b0;
    if (rst) begin
      exp_q.delete();
      model_acc = 0;
      return;
    end
    if (bus.out_valid === 1'b1 && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 64'(exp_q.size()), 64'd1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_bin", 64'(bus.out_bin), 64'(e.bin));
        check("out_tc", 64'(bus.out_tc), 64'(tc_of(e.bin)));
        check("out_err", 64'(bus.out_err), 64'(e.err));
        if (lat_chk) check("latency", 64'(step_no - e.step), 64'd2);
      end
      last_bin = int'(bus.out_bin);
      last_tc  = bus.out_tc;
      last_err = bus.out_err;
    end
    if (bus.in_valid && bus.in_ready === 1'b1) begin
      v = tc_value(bus.in_tc, ill);
      model_acc = bus.in_clear ? (v % MOD) : ((model_acc + v) % MOD);
      exp_q.push_back('{bin: model_acc, err: ERR_EN && ill, step: step_no});
      in_fire = 1'b1;
    end
  endtask

  task automatic step(input bit v, input logic [TW-1:0] tc, input bit clr, input bit ordy);
    @(negedge clk);
    rst           = 1'b0;
    bus.in_valid  = v;
    bus.in_tc     = tc;
    bus.in_clear  = clr;
    bus.out_ready = ordy;
    #1;
    step_no++;
    observe();
  endtask

  task automatic rst_step(input bit ordy);
    @(negedge clk);
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = ordy;
    #1;
    step_no++;
    check("in_ready_in_rst", 64'(bus.in_ready), 64'd0);
    observe();
  endtask

  task automatic send(input logic [TW-1:0] tc, input bit clr, input bit ordy, output int tries);
    tries = 0;
    do begin
      step(1'b1, tc, clr, ordy);
      tries++;
    end while (!in_fire && tries < 20);
    if (!in_fire) check("send_timeout", 64'(in_fire), 64'd1);
  endtask

  task automatic idle(input int n, input bit ordy);
    repeat (n) step(1'b0, '0, 1'b0, ordy);
  endtask

  function automatic logic [TW-1:0] rand_op();
    if ($urandom_range(0, 7) == 0) return TW'($urandom);
    return tc_of(int'($urandom_range(0, TW)));
  endfunction

  initial begin
    int            tries;
    int            idx;
    int            stall_acc;
    logic [3:0]    held_bin;
    logic [TW-1:0] ops[12];
    bit            clrs[12];
    logic [3:0]    ops5[3];
    int            m5_acc;
    int            got5[$];
    logic [3:0]    gottc5[$];
    int            exp5;

    bus.in_valid = 1'b0; bus.in_tc = '0; bus.in_clear = 1'b0; bus.out_ready = 1'b1;
    b5.in_valid  = 1'b0; b5.in_tc  = '0; b5.in_clear  = 1'b0; b5.out_ready  = 1'b1;

    // Reset state.
    rst_step(1'b1);
    rst_step(1'b1);
    idle(1, 1'b1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_bin", 64'(bus.out_bin), 64'd0);
    check("rst_out_tc", 64'(bus.out_tc), 64'd0);
    check("rst_out_err", 64'(bus.out_err), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Clear with 7, then add 6: results 7 and 2, each two cycles after accept.
    lat_chk = 1'b1;
    send(10'h07F, 1'b1, 1'b1, tries);
    send(10'h03F, 1'b0, 1'b1, tries);
    idle(3, 1'b1);
    check("t1_bin", 64'(last_bin), 64'd2);
    check("t1_tc", 64'(last_tc), 64'h003);

    // Eleven back-to-back ones: full throughput, outputs 1..10 then wrap to 0.
    for (int i = 0; i < 11; i++) begin
      send(10'h001, i == 0, 1'b1, tries);
      check("t2_one_per_cycle", 64'(tries), 64'd1);
    end
    idle(3, 1'b1);
    check("t2_wrap", 64'(last_bin), 64'd0);
    lat_chk = 1'b0;

    // Backpressure: out_ready low for 5 cycles with operands always offered.
    for (int i = 0; i < 12; i++) begin
      ops[i]  = rand_op();
      clrs[i] = ($urandom_range(0, 5) == 0);
    end
    idx = 0;
    stall_acc = 0;
    held_bin = '0;
    for (int c = 0; c < 60 && idx < 12; c++) begin
      step(1'b1, ops[idx], clrs[idx], c >= 5);
      if (in_fire) begin
        idx++;
        if (c < 5) stall_acc++;
      end
      if (c == 2) held_bin = bus.out_bin;
      if (c >= 2 && c < 5) begin
        check("t3_valid_held", 64'(bus.out_valid), 64'd1);
        check("t3_bin_stable", 64'(bus.out_bin), 64'(held_bin));
      end
      if (c == 4) check("t3_in_ready_low", 64'(bus.in_ready), 64'd0);
    end
    check("t3_accepts_in_stall", 64'(stall_acc), 64'd2);
    check("t3_all_sent", 64'(idx), 64'd12);
    idle(4, 1'b1);
    check("t3_drained", 64'(exp_q.size()), 64'd0);

    // Illegal operand after acc=4 contributes 0.
    send(10'h00F, 1'b1, 1'b1, tries);
    send(10'h005, 1'b0, 1'b1, tries);
    idle(3, 1'b1);
    check("t4_bin", 64'(last_bin), 64'd4);
    check("t4_err", 64'(last_err), 64'(ERR_EN));

    // Reset with S1 full and a held result; next operand starts from zero.
    send(10'h003, 1'b1, 1'b0, tries);
    send(10'h001, 1'b0, 1'b0, tries);
    idle(1, 1'b0);
    check("t5_pre_valid", 64'(bus.out_valid), 64'd1);
    check("t5_pre_in_ready", 64'(bus.in_ready), 64'd0);
    rst_step(1'b0);
    idle(1, 1'b0);
    check("t5_post_valid", 64'(bus.out_valid), 64'd0);
    check("t5_post_bin", 64'(bus.out_bin), 64'd0);
    send(10'h00F, 1'b0, 1'b1, tries);
    idle(3, 1'b1);
    check("t5_fresh_sum", 64'(last_bin), 64'd4);

    // Second channel at modulus 5: operands 4, 4, 3.
    ops5 = '{4'hF, 4'hF, 4'h7};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      b5.in_valid = (i < 3);
      b5.in_tc    = (i < 3) ? ops5[i] : 4'h0;
      #1;
      if (b5.out_valid === 1'b1 && b5.out_ready) begin
        got5.push_back(int'(b5.out_bin));
        gottc5.push_back(b5.out_tc);
      end
      if (i < 3) check("m5_in_ready", 64'(b5.in_ready), 64'd1);
    end
    check("m5_count", 64'(got5.size()), 64'd3);
    m5_acc = 0;
    for (int i = 0; i < 3 && i < got5.size(); i++) begin
      m5_acc = (m5_acc + $countones(ops5[i])) % MOD5;
      exp5 = m5_acc;
      check("m5_bin", 64'(got5[i]), 64'(exp5));
      check("m5_tc", 64'(gottc5[i]), 64'((1 << exp5) - 1));
    end

    idle(2, 1'b1);
    check("final_drain", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
